ppu_write_queue: RTL and testbench

Frame-synchronous write buffer between the Avalon-MM host port and the `ppu` register/table write port. It captures host writes during active video in a FIFO and replays them to the `ppu` only during vertical blank. Attribute, sprite and color table updates therefore never change mid-frame, which prevents tearing. It snoops `vcount` from `vga_counters` and emits the same `chipselect`/`write`/`address`/`writedata` bundle the `ppu` already consumes.

---
 rtl/ppu_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 48 ++++
 rtl/ppu_write_queue.sv | 131 +++++++++++++
 tb/tb_ppu_write_queue.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared types and constants for the ppu write queue: FSM states, FIFO entry layout,
// and the first vertical-blank line number.
package ppu_pkg;

  typedef enum logic [1:0] {
    ACTIVE,
    LATCH,
    DRAIN,
    SETTLED
  } wq_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wq_entry_t;

  localparam logic [9:0] PPU_VACTIVE = 10'd480;
  localparam int WQ_ENTRY_W = $bits(wq_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO. Pointers carry one extra wrap bit for full/empty.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ppu_write_queue.sv
// Frame-synchronous write buffer: host writes are queued during active video and replayed
// to the ppu in vertical blank. PPU_WQ_OVERFLOW_EN selects drop-with-sticky-flag over stalling.
module ppu_write_queue
  import ppu_pkg::*;
#(
  parameter int         DEPTH   = 16,
  parameter logic [9:0] VACTIVE = PPU_VACTIVE
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    chipselect,
  input  logic                    write,
  input  logic [15:0]             address,
  input  logic [31:0]             writedata,
  output logic                    waitrequest,
  input  logic [9:0]              vcount,
  output logic                    ppu_chipselect,
  output logic                    ppu_write,
  output logic [15:0]             ppu_address,
  output logic [31:0]             ppu_writedata,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output wq_state_t               state
);

  localparam int LW = $clog2(DEPTH) + 1;

  wq_state_t   state_q, state_d;
  logic [LW-1:0] batch_q, batch_d;
  logic        vblank;
  logic        host_req;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  wq_entry_t   tail_entry;
  wq_entry_t   head_entry;

  assign vblank     = (vcount >= VACTIVE);
  assign host_req   = chipselect && write;
  assign tail_entry = '{addr: address, data: writedata};
  assign state      = state_q;

  sync_fifo #(
    .WIDTH (WQ_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .din   (tail_entry),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

`ifdef PPU_WQ_OVERFLOW_EN
  logic overflow_q;

  assign waitrequest = 1'b0;
  assign push        = host_req && !fifo_full;
  assign overflow    = overflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   overflow_q <= 1'b0;
    else if (host_req && fifo_full) overflow_q <= 1'b1;
  end
`else
  // Full comes from registered pointers, so the host stall has no path from write.
  assign waitrequest = fifo_full;
  assign push        = host_req && !fifo_full;
  assign overflow    = 1'b0;
`endif

  // Leaving blank overrides every other transition; batch only changes in LATCH/DRAIN.
  always_comb begin
    state_d = state_q;
    batch_d = batch_q;
    pop     = 1'b0;
    if (!vblank) begin
      state_d = ACTIVE;
    end else begin
      case (state_q)
        ACTIVE:  state_d = LATCH;
        LATCH: begin
          batch_d = level;
          state_d = DRAIN;
        end
        DRAIN: begin
          if (batch_q == '0 || fifo_empty) begin
            state_d = SETTLED;
          end else begin
            pop     = 1'b1;
            batch_d = batch_q - LW'(1);
          end
        end
        SETTLED: state_d = SETTLED;
        default: state_d = ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACTIVE;
      batch_q <= '0;
    end else begin
      state_q <= state_d;
      batch_q <= batch_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ppu_write     <= 1'b0;
      ppu_address   <= '0;
      ppu_writedata <= '0;
    end else begin
      ppu_write <= pop;
      if (pop) begin
        ppu_address   <= head_entry.addr;
        ppu_writedata <= head_entry.data;
      end
    end
  end

  assign ppu_chipselect = ppu_write;

endmodule

// File: tb/tb_ppu_write_queue.sv
// Scoreboard bench for ppu_write_queue: drivers push expected entries, a negedge monitor
// pops and compares every ppu_write pulse; directed scenarios check timing and level.
`timescale 1ns/1ps
module tb_ppu_write_queue;
  import ppu_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [15:0] address = '0;
  logic [31:0] writedata = '0;
  logic [9:0]  vcount = '0;
  logic        waitrequest;
  logic        ppu_chipselect;
  logic        ppu_write;
  logic [15:0] ppu_address;
  logic [31:0] ppu_writedata;
  logic [4:0]  level;
  logic        overflow;
  wq_state_t   state;

  logic [47:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int blank_c0 = 0;
  int acc = 0;

  ppu_write_queue #(
    .DEPTH   (DEPTH),
    .VACTIVE (10'd480)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .chipselect     (chipselect),
    .write          (write),
    .address        (address),
    .writedata      (writedata),
    .waitrequest    (waitrequest),
    .vcount         (vcount),
    .ppu_chipselect (ppu_chipselect),
    .ppu_write      (ppu_write),
    .ppu_address    (ppu_address),
    .ppu_writedata  (ppu_writedata),
    .level          (level),
    .overflow       (overflow),
    .state          (state)
  );

  // clock/reset block
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every replayed write must match the head of the expected queue
  always @(negedge clk) begin : monitor
    logic [47:0] e;
    if (reset_n === 1'b1 && ppu_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 ppu_address, ppu_writedata);
      end else begin
        e = exp_q.pop_front();
        check("replay_entry", {16'h0, ppu_address, ppu_writedata}, {16'h0, e});
        check("ppu_chipselect", {63'h0, ppu_chipselect}, 64'h1);
      end
    end
  end

  // driver: called just after a rising edge; holds the write while waitrequest is high
  task automatic host_write(input logic [15:0] a, input logic [31:0] d, input bit keep,
                            output int acc_cyc);
    bit done = 1'b0;
    acc_cyc    = -1;
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (waitrequest === 1'b0) done = 1'b1;
      @(posedge clk);
      #1;
    end
    chipselect = 1'b0;
    write      = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL write_accept_timeout: got waitrequest stuck for addr 0x%0h, expected accept", a);
    end else begin
      acc_cyc = cyc;
      if (keep) exp_q.push_back({a, d});
    end
  endtask

  // Blank of `hold` cycles starting now (cycle C0); counts pulses, first must be C3, no gaps.
  task automatic run_blank(input string name, input int exp_n, input int hold);
    int n = 0;
    int first = -1;
    int last = -1;
    bit gap = 1'b0;
    blank_c0 = cyc;
    vcount   = 10'd480;
    for (int i = 0; i < hold + 4; i++) begin
      if (i == hold) begin
        @(posedge clk);
        #1;
        vcount = 10'd100;
      end
      @(negedge clk);
      if (ppu_write === 1'b1) begin
        if (first < 0) first = i;
        else if (i != last + 1) gap = 1'b1;
        last = i;
        n++;
      end
    end
    check({name, "_pulse_count"}, 64'(n), 64'(exp_n));
    if (exp_n > 0) begin
      check({name, "_first_cycle"}, 64'(first), 64'd3);
      check({name, "_no_gap"}, {63'h0, gap}, 64'h0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_level", 64'(level), 64'd0);
    check("reset_waitrequest", {63'h0, waitrequest}, 64'h0);
    check("reset_ppu_write", {63'h0, ppu_write}, 64'h0);
    check("reset_overflow", {63'h0, overflow}, 64'h0);
    check("reset_state", 64'(state), 64'(ACTIVE));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // visible-region hold
    vcount = 10'd100;
    host_write(16'h0003, 32'hDEADBEEF, 1'b1, acc);
    host_write(16'h0105, 32'h00000001, 1'b1, acc);
    host_write(16'h0201, 32'h00FF00FF, 1'b1, acc);
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (ppu_write === 1'b1) seen++;
      end
      check("visible_no_write", 64'(seen), 64'd0);
      check("visible_level", 64'(level), 64'd3);
      @(posedge clk);
      #1;
    end
    run_blank("visible", 3, 24);
    check("visible_level_after", 64'(level), 64'd0);
    check("visible_state_after", 64'(state), 64'(ACTIVE));

    // late write deferred to the next blank
    host_write(16'h0A0A, 32'h1111AAAA, 1'b1, acc);
    fork
      run_blank("late_a", 1, 24);
      begin
        repeat (3) @(posedge clk);
        #1;
        host_write(16'h0B0B, 32'h2222BBBB, 1'b1, acc);
      end
    join
    check("late_level_after", 64'(level), 64'd1);
    run_blank("late_b", 1, 24);
    check("late_b_level_after", 64'(level), 64'd0);

    vcount = 10'd0;
    for (int i = 0; i < 16; i++) host_write(16'h1000 + 16'(i), 32'hA5000000 + 32'(i), 1'b1, acc);
`ifdef PPU_WQ_OVERFLOW_EN
    host_write(16'h10FF, 32'hDEAD0017, 1'b0, acc);
    @(negedge clk);
    check("ovf_flag", {63'h0, overflow}, 64'h1);
    check("ovf_level", 64'(level), 64'd16);
    check("ovf_waitrequest", {63'h0, waitrequest}, 64'h0);
    @(posedge clk);
    #1;
    run_blank("ovf_replay", 16, 24);
    check("ovf_level_after", 64'(level), 64'd0);
    check("ovf_sticky", {63'h0, overflow}, 64'h1);
`else
    @(negedge clk);
    check("bp_level_full", 64'(level), 64'd16);
    check("bp_waitrequest", {63'h0, waitrequest}, 64'h1);
    check("bp_overflow_tied", {63'h0, overflow}, 64'h0);
    @(posedge clk);
    #1;
    fork
      host_write(16'h10FF, 32'hA5000010, 1'b1, acc);
      run_blank("bp_replay", 16, 24);
    join
    check("bp_accept_cycle", 64'(acc - blank_c0), 64'd4);
    check("bp_level_after", 64'(level), 64'd1);
    run_blank("bp_tail", 1, 24);
`endif

    // blank cut short after five pops
    vcount = 10'd0;
    for (int i = 0; i < 16; i++) host_write(16'h2000 + 16'(i), 32'hC0DE0000 + 32'(i), 1'b1, acc);
    run_blank("cut_short", 5, 7);
    check("cut_state", 64'(state), 64'(ACTIVE));
    check("cut_level", 64'(level), 64'd11);
    run_blank("cut_rest", 11, 24);
    check("cut_level_after", 64'(level), 64'd0);

    // reset mid-drain: one entry replayed, the rest discarded
    vcount = 10'd0;
    for (int i = 0; i < 4; i++) host_write(16'h3000 + 16'(i), 32'h77770000 + 32'(i), 1'b1, acc);
    vcount = 10'd480;
    repeat (4) @(negedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_ppu_write", {63'h0, ppu_write}, 64'h0);
    check("rst_ppu_chipselect", {63'h0, ppu_chipselect}, 64'h0);
    check("rst_ppu_address", 64'(ppu_address), 64'h0);
    check("rst_ppu_writedata", 64'(ppu_writedata), 64'h0);
    check("rst_waitrequest", {63'h0, waitrequest}, 64'h0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_overflow", {63'h0, overflow}, 64'h0);
    check("rst_state", 64'(state), 64'(ACTIVE));
    vcount = 10'd100;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_blank("after_reset", 0, 24);
    check("after_reset_level", 64'(level), 64'd0);

    @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
